axi_rd_arbiter_3x1: RTL and testbench
=====================================

Name: axi_rd_arbiter_3x1

Overview:
- Read-channel arbiter that shares the single outer AXI read port between three masters: I-cache (index 0), D-cache (index 1) and the uncached path (index 2).
- Sits between the cache/uncached AXI masters and the top-level AXI read signals.
- One outstanding read transaction at a time; each burst is forwarded to completion before the next grant.
- Write channels are not handled here.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_araddr  in  3*ADDR_W  per-master AR address; master i occupies bits [i*ADDR_W +: ADDR_W]
- m_arlen  in  3*4  per-master burst length (beats-1)
- m_arsize  in  3*3  per-master beat size
- m_arvalid  in  3  per-master AR valid
- m_arready  out  3  per-master AR accept pulse
- m_rdata  out  DATA_W  read data, broadcast to all masters
- m_rlast  out  1  last beat, broadcast
- m_rvalid  out  3  per-master R valid; only the granted bit can be 1
- m_rready  in  3  per-master R ready
- arid  out  4  outer AR id = {2'b00, grant index}
- araddr  out  ADDR_W  outer AR address
- arlen  out  4  outer burst length
- arsize  out  3  outer beat size
- arburst  out  2  constant 2'b01 (INCR)
- arlock  out  2  constant 0
- arcache  out  4  constant 0
- arprot  out  3  constant 0
- arvalid  out  1  outer AR valid
- arready  in  1  outer AR ready
- rid  in  4  ignored
- rdata  in  DATA_W  outer read data
- rresp  in  2  ignored
- rlast  in  1  outer last beat
- rvalid  in  1  outer R valid
- rready  out  1  outer R ready

Behaviour:
- Clock/reset: single clock clk. rst is synchronous and active-high.
- Reset values: state=IDLE, grant=0, arvalid=0, rready=0, m_arready=0, m_rvalid=0, araddr/arlen/arsize registers=0, round-robin pointer=2.
- State machine: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - If any m_arvalid is high, the arbiter picks a winner w.
  - m_arready[w]=1 combinationally in that same cycle; no other bit is set.
  - m_araddr/arlen/arsize of w are latched, grant<=w, and the state moves to ADDR.
  - If no m_arvalid is high, the block stays in IDLE and all m_arready=0.
- ADDR:
  - arvalid=1 and the latched fields are driven steadily.
  - On arvalid&&arready the state moves to DATA. arvalid drops in the following cycle.
  - Fields must not change while arvalid=1 and arready=0.
- DATA:
  - rready=m_rready[grant].
  - m_rvalid[grant]=rvalid; all other m_rvalid bits are 0.
  - m_rdata=rdata and m_rlast=rlast are combinational pass-through.
  - On rvalid&&rready&&rlast the state returns to IDLE.
  - Beat count is not checked; the outer rlast is authoritative.
- Latency:
  - Accept to outer arvalid: 1 cycle.
  - R beats: 0 cycles of added latency.
  - Last beat to next grant: 1 idle cycle, because a grant only happens while in IDLE.
- Requests arriving during ADDR/DATA wait: m_arready stays 0 until the arbiter returns to IDLE.
- Simultaneous requests:
  - Resolved by the priority scheme below.
  - Losers keep m_arvalid high and are served in later IDLE cycles.
  - No request is ever dropped.
- rid/rresp: ignored, with no error reporting.
- arlen=0 (single beat): first beat must carry rlast=1, and the FSM returns to IDLE after it.
- Reset mid-transaction: the FSM goes to IDLE immediately and the in-flight burst is abandoned. The outer slave is reset by the same rst.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin arbitration.
  - Search order starts at (ptr+1) mod 3.
  - ptr<=w on each grant.
  - Reset ptr=2, so index 0 has first priority after reset.
- Undefined: fixed priority D-cache(1) > uncached(2) > I-cache(0); the ptr register is not implemented.

Test Plan:
- Reset, then I-cache only, araddr=0xBFC00000, arlen=7 -> m_arready[0] in the request cycle; outer arvalid next cycle with arid=0, araddr=0xBFC00000, arlen=7; 8 beats routed to m_rvalid[0] only; return to IDLE after rlast.
- Uncached single read, arlen=0, arsize=2, araddr=0x1FAF0000 -> arid=2; one beat with rlast; m_rdata equals outer rdata.
- All three request in the same cycle, fixed priority -> grant order 1, 2, 0; each burst completes before the next arvalid.
- Same stimulus with ARB_RR_EN, two rounds of all three requesting continuously -> grant order 0, 1, 2, 0, 1, 2.
- arready held low for 5 cycles in ADDR -> arvalid, araddr and arlen stay stable. m_rready[grant] toggling in DATA -> outer rready follows it; no beat is lost or duplicated.
- rst asserted mid-DATA after beat 3 of 8 -> next cycle arvalid=0, rready=0, all m_rvalid=0; a new request after reset is granted normally.

Source files
------------

// File: rtl/axi_rd_arbiter_3x1.sv
// Three-master AXI read-channel arbiter (I-cache=0, D-cache=1, uncached=2) onto one outer read port.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority 1 > 2 > 0.
module axi_rd_arbiter_3x1 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3*ADDR_W-1:0]   m_araddr,
  input  logic [11:0]           m_arlen,
  input  logic [8:0]            m_arsize,
  input  logic [2:0]            m_arvalid,
  output logic [2:0]            m_arready,
  output logic [DATA_W-1:0]     m_rdata,
  output logic                  m_rlast,
  output logic [2:0]            m_rvalid,
  input  logic [2:0]            m_rready,
  output logic [3:0]            arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [3:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t              r_state;
  logic [1:0]          r_grant;
  logic [ADDR_W-1:0]   r_araddr;
  logic [3:0]          r_arlen;
  logic [2:0]          r_arsize;
  logic                r_arvalid;

  logic                w_any;
  logic [1:0]          w_win;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [3:0]          w_sel_len;
  logic [2:0]          w_sel_size;
  logic                w_sel_rready;
  logic                w_unused;

  assign w_unused = ^{rid, rresp};
  assign w_any    = |m_arvalid;

`ifdef ARB_RR_EN
  logic [1:0] r_ptr;
  logic [1:0] w_c0, w_c1, w_c2;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    inc3 = (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Search starts one past the last winner so every requester is reached within three grants.
  always_comb begin
    w_c0 = inc3(r_ptr);
    w_c1 = inc3(w_c0);
    w_c2 = inc3(w_c1);
    if (m_arvalid[w_c0])      w_win = w_c0;
    else if (m_arvalid[w_c1]) w_win = w_c1;
    else                      w_win = w_c2;
  end
`else
  always_comb begin
    if (m_arvalid[1])      w_win = 2'd1;
    else if (m_arvalid[2]) w_win = 2'd2;
    else                   w_win = 2'd0;
  end
`endif

  always_comb begin
    w_sel_addr = m_araddr[0 +: ADDR_W];
    w_sel_len  = m_arlen[3:0];
    w_sel_size = m_arsize[2:0];
    case (w_win)
      2'd1: begin
        w_sel_addr = m_araddr[ADDR_W +: ADDR_W];
        w_sel_len  = m_arlen[7:4];
        w_sel_size = m_arsize[5:3];
      end
      2'd2: begin
        w_sel_addr = m_araddr[2*ADDR_W +: ADDR_W];
        w_sel_len  = m_arlen[11:8];
        w_sel_size = m_arsize[8:6];
      end
      default: ;
    endcase
  end

  always_comb begin
    case (r_grant)
      2'd1:    w_sel_rready = m_rready[1];
      2'd2:    w_sel_rready = m_rready[2];
      default: w_sel_rready = m_rready[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_grant   <= 2'd0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
`ifdef ARB_RR_EN
      r_ptr     <= 2'd2;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant   <= w_win;
            r_araddr  <= w_sel_addr;
            r_arlen   <= w_sel_len;
            r_arsize  <= w_sel_size;
            r_arvalid <= 1'b1;
            r_state   <= S_ADDR;
`ifdef ARB_RR_EN
            r_ptr     <= w_win;
`endif
          end
        end
        S_ADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          // Outer rlast alone ends the burst; beats are not counted against arlen.
          if (rvalid && w_sel_rready && rlast) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    m_arready = 3'b000;
    if (r_state == S_IDLE && w_any && !rst) m_arready[w_win] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < 3; i++)
      m_rvalid[i] = (r_state == S_DATA) && (r_grant == 2'(i)) && rvalid;
  end

  assign rready  = (r_state == S_DATA) && w_sel_rready;
  assign m_rdata = rdata;
  assign m_rlast = rlast;

  assign arid    = {2'b00, r_grant};
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arsize  = r_arsize;
  assign arvalid = r_arvalid;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

endmodule

// File: tb/tb_axi_rd_arbiter_3x1.sv
// Directed scoreboard bench for axi_rd_arbiter_3x1; expected AR fields and R beats are queued when driven.
module tb_axi_rd_arbiter_3x1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr [3];
  logic [3:0]  len  [3];
  logic [2:0]  size [3];
  logic [95:0] m_araddr;
  logic [11:0] m_arlen;
  logic [8:0]  m_arsize;
  logic [2:0]  m_arvalid;
  logic [2:0]  m_arready;
  logic [31:0] m_rdata;
  logic        m_rlast;
  logic [2:0]  m_rvalid;
  logic [2:0]  m_rready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
  } ar_t;

  ar_t         arq [$];
  logic [32:0] rq  [$];

  assign m_araddr = {addr[2], addr[1], addr[0]};
  assign m_arlen  = {len[2], len[1], len[0]};
  assign m_arsize = {size[2], size[1], size[0]};

  always #5 clk = ~clk;

  axi_rd_arbiter_3x1 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arbitration and address phase; requester valids are set by the caller beforehand.
  task automatic do_addr(input int id, input int stall);
    int  t;
    ar_t e;
    #1;
    t = 0;
    while (m_arready == 3'b000 && t < 20) begin
      nxt();
      #1;
      t++;
    end
    chk("grant_wait", 64'(t), 64'd0);
    chk("m_arready", 64'(m_arready), 64'(3'b001 << id));
    if (m_arready == 3'b000) return;
    arq.push_back('{4'(id), addr[id], len[id], size[id]});
    nxt();
    m_arvalid[id] = 1'b0;
    #1;
    e = arq.pop_front();
    chk("arvalid", 64'(arvalid), 64'd1);
    chk("arid", 64'(arid), 64'(e.id));
    chk("araddr", 64'(araddr), 64'(e.addr));
    chk("arlen", 64'(arlen), 64'(e.len));
    chk("arsize", 64'(arsize), 64'(e.size));
    chk("m_arready_busy", 64'(m_arready), 64'd0);
    for (int s = 0; s < stall; s++) begin
      nxt();
      #1;
      chk("arvalid_stall", 64'(arvalid), 64'd1);
      chk("araddr_stall", 64'(araddr), 64'(e.addr));
      chk("arlen_stall", 64'(arlen), 64'(e.len));
    end
    arready = 1'b1;
    nxt();
    arready = 1'b0;
    #1;
    chk("arvalid_drop", 64'(arvalid), 64'd0);
  endtask

  // Outer slave delivers beats; returns after maxb accepted beats.
  task automatic do_data(input int id, input bit tog, input int maxb);
    int          b;
    int          cyc;
    bit          newb;
    logic [31:0] d;
    logic [32:0] e;
    b = 0;
    cyc = 0;
    newb = 1'b1;
    d = '0;
    while (b < maxb && cyc < 100) begin
      if (newb) begin
        d      = $urandom;
        rdata  = d;
        rlast  = (b == int'(len[id]));
        rvalid = 1'b1;
        rq.push_back({rlast, d});
        newb   = 1'b0;
      end
      m_rready[id] = tog ? ((cyc % 3) != 1) : 1'b1;
      #1;
      chk("rready_follow", 64'(rready), 64'(m_rready[id]));
      chk("m_rvalid", 64'(m_rvalid), 64'(3'b001 << id));
      chk("m_arready_data", 64'(m_arready), 64'd0);
      if (m_rready[id]) begin
        e = rq.pop_front();
        chk("m_rdata_beat", {31'd0, m_rlast, m_rdata}, 64'(e));
        b++;
        newb = 1'b1;
      end
      nxt();
      cyc++;
    end
    chk("beat_count", 64'(b), 64'(maxb));
    if (maxb == int'(len[id]) + 1) begin
      rvalid   = 1'b0;
      rlast    = 1'b0;
      m_rready = 3'b111;
      #1;
      chk("m_rvalid_idle", 64'(m_rvalid), 64'd0);
      chk("rready_idle", 64'(rready), 64'd0);
    end
  endtask

  task automatic run_txn(input int id, input int stall, input bit tog);
    do_addr(id, stall);
    do_data(id, tog, int'(len[id]) + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0;
      len[i]  = '0;
      size[i] = '0;
    end
    m_arvalid = 3'b111;
    m_rready  = 3'b111;
    arready   = 1'b0;
    rid       = 4'hF;
    rdata     = '0;
    rresp     = 2'b10;
    rlast     = 1'b0;
    rvalid    = 1'b0;
    nxt();
    nxt();
    chk("rst_m_arready", 64'(m_arready), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_m_rvalid", 64'(m_rvalid), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    chk("rst_arid", 64'(arid), 64'd0);
    chk("arburst", 64'(arburst), 64'd1);
    chk("ar_consts", 64'({arlock, arcache, arprot}), 64'd0);
    m_arvalid = 3'b000;
    rst = 1'b0;
    nxt();
    chk("idle_no_req", 64'(m_arready), 64'd0);

    // I-cache 8-beat burst
    addr[0] = 32'hBFC0_0000; len[0] = 4'd7; size[0] = 3'd2;
    m_arvalid = 3'b001;
    run_txn(0, 0, 1'b0);

    // Uncached single beat
    addr[2] = 32'h1FAF_0000; len[2] = 4'd0; size[2] = 3'd2;
    m_arvalid = 3'b100;
    run_txn(2, 0, 1'b0);

    // D-cache with stalled arready and toggling rready
    addr[1] = 32'h8000_1000; len[1] = 4'd3; size[1] = 3'd2;
    m_arvalid = 3'b010;
    run_txn(1, 5, 1'b1);

    // Simultaneous requests from a fresh reset
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    addr[0] = 32'h0000_0100; len[0] = 4'd1; size[0] = 3'd2;
    addr[1] = 32'h0000_0200; len[1] = 4'd2; size[1] = 3'd1;
    addr[2] = 32'h0000_0300; len[2] = 4'd0; size[2] = 3'd0;
    m_arvalid = 3'b111;
`ifdef ARB_RR_EN
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        run_txn(i, 0, 1'b0);
        if (r == 0) m_arvalid[i] = 1'b1;
      end
    end
`else
    run_txn(1, 0, 1'b0);
    run_txn(2, 0, 1'b0);
    run_txn(0, 0, 1'b0);
`endif
    chk("all_served", 64'(m_arvalid), 64'd0);

    // Reset in the middle of a burst
    addr[0] = 32'h0000_4000; len[0] = 4'd7; size[0] = 3'd2;
    m_arvalid = 3'b001;
    do_addr(0, 0);
    do_data(0, 1'b0, 3);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    #1;
    chk("rst_mid_arvalid", 64'(arvalid), 64'd0);
    chk("rst_mid_rready", 64'(rready), 64'd0);
    chk("rst_mid_m_rvalid", 64'(m_rvalid), 64'd0);
    rvalid = 1'b0;
    rlast  = 1'b0;
    rq.delete();
    m_rready = 3'b111;
    addr[2] = 32'h1FAF_0040; len[2] = 4'd1; size[2] = 3'd2;
    m_arvalid = 3'b100;
    run_txn(2, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
